// File: rtl/gate_selftest_seq_if.sv
// Handshake and data bundle between the gate self-test sequencer and its controller.
// The slave side is the sequencer; the master side owns start and the gate result bus.
interface gate_selftest_seq_if #(
    parameter int ERR_W = 6
);
    logic             start;
    logic             gate_a;
    logic             gate_b;
    logic [7:0]       result_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       fail_vec;

    modport master (
        output start, result_in,
        input  gate_a, gate_b, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, result_in,
        output gate_a, gate_b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_selftest_seq.sv
// Walks the two-input gate block through all four input vectors, compares the 8-bit
// result bus against a golden truth table and reports a saturating mismatch count.
module gate_selftest_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_selftest_seq_if.slave bus_io
);
    localparam int              SUM_W       = ((ERR_W > 4) ? ERR_W : 4) + 1;
    localparam logic [SUM_W-1:0] ERR_MAX    = SUM_W'((64'd1 << ERR_W) - 64'd1);
    localparam bit              HAS_SETTLE  = (SETTLE_CYCLES > 0);
    localparam logic [3:0]      SETTLE_LAST = HAS_SETTLE ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             gate_a_q, gate_a_d;
    logic             gate_b_q, gate_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;

    // Golden response per vector index {a,b}; bit order matches the result bus.
    logic [7:0] exp_tbl [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_exp
        localparam bit A = ((gi >> 1) & 1) != 0;
        localparam bit B = (gi & 1) != 0;
        assign exp_tbl[gi] = {A, ~(A ^ B), ~(A | B), ~(A & B), ~A, A ^ B, A | B, A & B};
    end

    logic [7:0]       mism;
    logic [3:0]       pop;
    logic [SUM_W-1:0] err_sum;
    logic [ERR_W-1:0] err_sat;

    always_comb begin
        mism = bus_io.result_in ^ exp_tbl[idx_q];
        pop  = '0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'b000, mism[i]};
        end
        err_sum = {{(SUM_W-ERR_W){1'b0}}, err_q} + {{(SUM_W-4){1'b0}}, pop};
        err_sat = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
    end

    // Outputs lag the state by one register stage, so busy_q is still high on the
    // first DONE cycle; that is what marks the DONE entry for the done pulse.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        gate_a_d = gate_a_q;
        gate_b_d = gate_b_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        done_d   = 1'b0;
        busy_d   = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);

        case (state_q)
            S_IDLE: begin
                if (bus_io.start) begin
                    state_d = S_DRIVE;
                    idx_d   = 2'd0;
                    err_d   = '0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                gate_a_d = idx_q[1];
                gate_b_d = idx_q[0];
                cnt_d    = 4'd0;
                state_d  = HAS_SETTLE ? S_SETTLE : S_CHECK;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                err_d = err_sat;
                if (mism != 8'd0) begin
                    fail_d[idx_q] = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                done_d = busy_q;
                if (busy_q) begin
                    pass_d = (err_q == '0);
                end
                if (bus_io.start) begin
                    state_d = S_DRIVE;
                    idx_d   = 2'd0;
                    err_d   = '0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 4'd0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fail_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    assign bus_io.gate_a    = gate_a_q;
    assign bus_io.gate_b    = gate_b_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
    assign bus_io.pass      = pass_q;
    assign bus_io.err_count = err_q;
    assign bus_io.fail_vec  = fail_q;
endmodule

// File: tb/tb_gate_selftest_seq.sv
// Bench for gate_selftest_seq: three instances (settle 2 / settle 0 / narrow counter)
// each fed by a behavioural gate model with per-vector fault masks.
module tb_gate_selftest_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] mask0 [4];
    logic [7:0] mask1 [4];
    logic [7:0] mask2 [4];
    logic       stuck_xor;

    gate_selftest_seq_if #(.ERR_W(6)) if0 ();
    gate_selftest_seq_if #(.ERR_W(6)) if1 ();
    gate_selftest_seq_if #(.ERR_W(4)) if2 ();

    gate_selftest_seq #(.SETTLE_CYCLES(2), .ERR_W(6)) u0 (.clk(clk), .rst_n(rst_n), .bus_io(if0.slave));
    gate_selftest_seq #(.SETTLE_CYCLES(0), .ERR_W(6)) u1 (.clk(clk), .rst_n(rst_n), .bus_io(if1.slave));
    gate_selftest_seq #(.SETTLE_CYCLES(2), .ERR_W(4)) u2 (.clk(clk), .rst_n(rst_n), .bus_io(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth of each gate written as arithmetic on the 0/1 input values.
    function automatic logic [7:0] golden(input logic a, input logic b);
        int ia;
        int ib;
        logic [7:0] r;
        ia = a ? 1 : 0;
        ib = b ? 1 : 0;
        r[0] = (ia * ib) == 1;
        r[1] = (ia + ib) >= 1;
        r[2] = (ia + ib) == 1;
        r[3] = ia == 0;
        r[4] = (ia * ib) == 0;
        r[5] = (ia + ib) == 0;
        r[6] = (ia + ib) != 1;
        r[7] = ia == 1;
        return r;
    endfunction

    always_comb begin
        if0.result_in = golden(if0.gate_a, if0.gate_b) ^ mask0[{if0.gate_a, if0.gate_b}];
        if (stuck_xor) if0.result_in[2] = 1'b0;
    end
    always_comb if1.result_in = golden(if1.gate_a, if1.gate_b) ^ mask1[{if1.gate_a, if1.gate_b}];
    always_comb if2.result_in = golden(if2.gate_a, if2.gate_b) ^ mask2[{if2.gate_a, if2.gate_b}];

    function automatic int model_err(input logic [7:0] m [4], input int max_v);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += $countones(m[i]);
        return (s > max_v) ? max_v : s;
    endfunction

    function automatic logic [3:0] model_fail(input logic [7:0] m [4]);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m[i] != 8'd0);
        return r;
    endfunction

    function automatic logic [7:0] rand_mask();
        if ($urandom_range(0, 1) == 0) return 8'd0;
        return 8'($urandom);
    endfunction

    task automatic run0(output int lat);
        @(posedge clk); #1 if0.start = 1'b1;
        @(posedge clk); #1 if0.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (if0.done) begin lat = n; break; end
        end
    endtask

    task automatic run2(output int lat);
        @(posedge clk); #1 if2.start = 1'b1;
        @(posedge clk); #1 if2.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (if2.done) begin lat = n; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        stuck_xor = 1'b0;
        for (int i = 0; i < 4; i++) begin mask0[i] = 8'd0; mask1[i] = 8'd0; mask2[i] = 8'd0; end
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({if0.gate_a, if0.gate_b} !== 2'b00) begin errors++; $display("FAIL reset_gates got %b want 00", {if0.gate_a, if0.gate_b}); end
        checks++; if ({if0.busy, if0.done, if0.pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {if0.busy, if0.done, if0.pass}); end
        checks++; if (if0.err_count !== 6'd0) begin errors++; $display("FAIL reset_err got %0d want 0", if0.err_count); end
        checks++; if (if0.fail_vec !== 4'd0) begin errors++; $display("FAIL reset_failvec got %b want 0000", if0.fail_vec); end
        checks++; if ({if1.busy, if1.done, if2.busy, if2.done} !== 4'b0000) begin errors++; $display("FAIL reset_others got %b want 0000", {if1.busy, if1.done, if2.busy, if2.done}); end
        rst_n = 1'b1;
        $display("reset: outputs sampled after two reset edges");
    endtask

    task automatic test_golden();
        int lat;
        run0(lat);
        $display("golden run: lat=%0d err=%0d fail_vec=%b pass=%b", lat, if0.err_count, if0.fail_vec, if0.pass);
        checks++; if (lat != 17) begin errors++; $display("FAIL golden_latency got %0d want 17", lat); end
        checks++; if ({if0.pass, if0.busy} !== 2'b10) begin errors++; $display("FAIL golden_pass_busy got %b want 10", {if0.pass, if0.busy}); end
        checks++; if (if0.err_count !== 6'd0) begin errors++; $display("FAIL golden_err got %0d want 0", if0.err_count); end
        checks++; if (if0.fail_vec !== 4'b0000) begin errors++; $display("FAIL golden_failvec got %b want 0000", if0.fail_vec); end
        @(posedge clk); #1;
        checks++; if ({if0.done, if0.pass, if0.gate_a, if0.gate_b} !== 4'b0111) begin errors++; $display("FAIL golden_hold got %b want 0111", {if0.done, if0.pass, if0.gate_a, if0.gate_b}); end
    endtask

    task automatic test_stuck_xor();
        int lat;
        stuck_xor = 1'b1;
        run0(lat);
        stuck_xor = 1'b0;
        $display("stuck xor run: lat=%0d err=%0d fail_vec=%b pass=%b", lat, if0.err_count, if0.fail_vec, if0.pass);
        checks++; if (lat != 17) begin errors++; $display("FAIL stuck_latency got %0d want 17", lat); end
        checks++; if (if0.err_count !== 6'd2) begin errors++; $display("FAIL stuck_err got %0d want 2", if0.err_count); end
        checks++; if ({if0.fail_vec, if0.pass} !== 5'b0110_0) begin errors++; $display("FAIL stuck_failvec_pass got %b want 01100", {if0.fail_vec, if0.pass}); end
    endtask

    task automatic test_all_inverted();
        int lat;
        logic d2;
        for (int i = 0; i < 4; i++) begin mask0[i] = 8'hFF; mask2[i] = 8'hFF; end
        @(posedge clk); #1 if0.start = 1'b1; if2.start = 1'b1;
        @(posedge clk); #1 if0.start = 1'b0; if2.start = 1'b0;
        lat = -1; d2 = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (if0.done) begin lat = n; d2 = if2.done; break; end
        end
        $display("inverted run: lat=%0d err6=%0d err4=%0d fail=%b/%b", lat, if0.err_count, if2.err_count, if0.fail_vec, if2.fail_vec);
        checks++; if (lat != 17 || d2 !== 1'b1) begin errors++; $display("FAIL inv_latency got %0d/%b want 17/1", lat, d2); end
        checks++; if (if0.err_count !== 6'd32) begin errors++; $display("FAIL inv_err6 got %0d want 32", if0.err_count); end
        checks++; if (if2.err_count !== 4'd15) begin errors++; $display("FAIL inv_err4_sat got %0d want 15", if2.err_count); end
        checks++; if ({if0.fail_vec, if2.fail_vec, if0.pass, if2.pass} !== 10'b1111_1111_00) begin errors++; $display("FAIL inv_failvec got %b want 1111111100", {if0.fail_vec, if2.fail_vec, if0.pass, if2.pass}); end
        for (int i = 0; i < 4; i++) begin mask0[i] = 8'd0; mask2[i] = 8'd0; end
    endtask

    task automatic test_random();
        int lat;
        int e6;
        int e4;
        logic [3:0] fv;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) begin mask0[i] = rand_mask(); mask2[i] = mask0[i]; end
            e6 = model_err(mask0, 63);
            e4 = model_err(mask0, 15);
            fv = model_fail(mask0);
            run0(lat);
            $display("random run %0d dut0: lat=%0d err=%0d/%0d fail=%b/%b", it, lat, if0.err_count, e6, if0.fail_vec, fv);
            checks++; if (lat != 17) begin errors++; $display("FAIL rand_latency got %0d want 17", lat); end
            checks++; if (if0.err_count !== 6'(e6)) begin errors++; $display("FAIL rand_err6 got %0d want %0d", if0.err_count, e6); end
            checks++; if (if0.fail_vec !== fv) begin errors++; $display("FAIL rand_failvec got %b want %b", if0.fail_vec, fv); end
            checks++; if (if0.pass !== (e6 == 0)) begin errors++; $display("FAIL rand_pass got %b want %b", if0.pass, (e6 == 0)); end
            run2(lat);
            $display("random run %0d dut2: lat=%0d err=%0d/%0d", it, lat, if2.err_count, e4);
            checks++; if (lat != 17 || if2.err_count !== 4'(e4)) begin errors++; $display("FAIL rand_err4 got %0d lat %0d want %0d lat 17", if2.err_count, lat, e4); end
        end
        for (int i = 0; i < 4; i++) begin mask0[i] = 8'd0; mask2[i] = 8'd0; end
    endtask

    task automatic test_back_to_back();
        int lat;
        int lat2;
        logic busy_ok;
        for (int i = 0; i < 4; i++) mask0[i] = 8'h01;
        @(posedge clk); #1 if0.start = 1'b1;
        @(posedge clk); #1;
        lat = -1; busy_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (if0.done) begin lat = n; break; end
            if (if0.busy !== 1'b1) busy_ok = 1'b0;
        end
        checks++; if (lat != 17 || !busy_ok) begin errors++; $display("FAIL b2b_first got lat %0d busy_ok %b want 17 1", lat, busy_ok); end
        checks++; if ({if0.busy, if0.err_count} !== {1'b0, 6'd0}) begin errors++; $display("FAIL b2b_restart_clear got busy %b err %0d want 0 0", if0.busy, if0.err_count); end
        if0.start = 1'b0;
        for (int i = 0; i < 4; i++) mask0[i] = 8'd0;
        lat2 = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (if0.done) begin lat2 = n; break; end
        end
        $display("back-to-back: first lat=%0d second lat=%0d err=%0d pass=%b", lat, lat2, if0.err_count, if0.pass);
        checks++; if (lat2 != 17) begin errors++; $display("FAIL b2b_second_latency got %0d want 17", lat2); end
        checks++; if ({if0.pass, if0.err_count} !== {1'b1, 6'd0}) begin errors++; $display("FAIL b2b_second_result got pass %b err %0d want 1 0", if0.pass, if0.err_count); end
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        for (int i = 0; i < 4; i++) mask0[i] = 8'hFF;
        @(posedge clk); #1 if0.start = 1'b1;
        @(posedge clk); #1 if0.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++; if ({if0.gate_a, if0.gate_b, if0.busy} !== 3'b101 || if0.err_count !== 6'd16) begin errors++; $display("FAIL midrun_state got ab/busy %b err %0d want 101 16", {if0.gate_a, if0.gate_b, if0.busy}, if0.err_count); end
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        checks++; if ({if0.gate_a, if0.gate_b, if0.busy, if0.done, if0.pass} !== 5'b00000) begin errors++; $display("FAIL midrun_reset_flags got %b want 00000", {if0.gate_a, if0.gate_b, if0.busy, if0.done, if0.pass}); end
        checks++; if (if0.err_count !== 6'd0 || if0.fail_vec !== 4'd0) begin errors++; $display("FAIL midrun_reset_counts got %0d %b want 0 0000", if0.err_count, if0.fail_vec); end
        saw_done = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (if0.done || if0.busy) saw_done = 1'b1;
        end
        $display("reset mid-run: activity after reset=%b", saw_done);
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrun_idle got activity %b want 0", saw_done); end
        for (int i = 0; i < 4; i++) mask0[i] = 8'd0;
    endtask

    task automatic test_no_settle();
        int lat;
        int e;
        logic [3:0] fv;
        logic [1:0] seq [4];
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 4; i++) mask1[i] = rand_mask();
            e = model_err(mask1, 63);
            fv = model_fail(mask1);
            for (int i = 0; i < 4; i++) seq[i] = 2'bxx;
            @(posedge clk); #1 if1.start = 1'b1;
            @(posedge clk); #1 if1.start = 1'b0;
            lat = -1;
            for (int n = 1; n <= 40; n++) begin
                @(posedge clk); #1;
                if (n % 2 == 1 && n <= 7) seq[n/2] = {if1.gate_a, if1.gate_b};
                if (if1.done) begin lat = n; break; end
            end
            $display("no-settle run %0d: lat=%0d seq=%b %b %b %b err=%0d/%0d", rep, lat, seq[0], seq[1], seq[2], seq[3], if1.err_count, e);
            checks++; if (lat != 9) begin errors++; $display("FAIL nosettle_latency got %0d want 9", lat); end
            for (int v = 0; v < 4; v++) begin
                checks++; if (seq[v] !== 2'(v)) begin errors++; $display("FAIL nosettle_vec%0d got %b want %b", v, seq[v], 2'(v)); end
            end
            checks++; if (if1.err_count !== 6'(e) || if1.fail_vec !== fv) begin errors++; $display("FAIL nosettle_result got %0d %b want %0d %b", if1.err_count, if1.fail_vec, e, fv); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_golden();
        test_stuck_xor();
        test_all_inverted();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_no_settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
